// File: rtl/mat_operand_loader.sv
// Operand feeder for the 4x4 matrix add/sub path: streams 16 A entries then 16 B entries,
// packs them MSB-first, pulses add_en and holds operands until the path reports finish.
module mat_operand_loader #(
  parameter int ENTRY_W   = 4,
  parameter int N_ENTRIES = 16,
  localparam int BUS_W    = ENTRY_W * N_ENTRIES,
  localparam int IDX_W    = $clog2(N_ENTRIES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_load,
  input  logic               op_sign,
  input  logic               abort,
  input  logic [ENTRY_W-1:0] entry_in,
  input  logic               entry_valid,
  output logic               entry_ready,
  output logic [BUS_W-1:0]   mat_A,
  output logic [BUS_W-1:0]   mat_B,
  output logic               sign,
  output logic               add_en,
  input  logic               add_finish,
  output logic               load_sel,
  output logic [IDX_W-1:0]   load_idx,
  output logic               busy,
  output logic               done,
  output logic [2:0]         state_dbg
);

  // Handshake: an entry transfers on a rising clk edge where entry_valid and entry_ready are
  // both high; entry_ready is high only while loading, and entry_in is ignored otherwise.

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    FIRE   = 3'd3,
    WAIT   = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_ENTRIES - 1);

  state_t state_q, state_d;
  logic   xfer;
  logic   idx_last;

  assign entry_ready = (state_q == LOAD_A) || (state_q == LOAD_B);
  assign xfer        = entry_valid && entry_ready;
  assign idx_last    = (load_idx == IDX_LAST);
  assign add_en      = (state_q == FIRE);
  assign load_sel    = (state_q == LOAD_B);
  assign busy        = (state_q != IDLE) && (state_q != DONE);
  assign done        = (state_q == DONE);
  assign state_dbg   = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start_load) state_d = LOAD_A;
      LOAD_A: begin
        if (abort)                 state_d = IDLE;
        else if (xfer && idx_last) state_d = LOAD_B;
      end
      LOAD_B: begin
        if (abort)                 state_d = IDLE;
        else if (xfer && idx_last) state_d = FIRE;
      end
      FIRE:    state_d = WAIT;
      WAIT:    if (add_finish) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Operand datapath; abort wins over a same-cycle transfer so that entry is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mat_A    <= '0;
      mat_B    <= '0;
      sign     <= 1'b0;
      load_idx <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start_load) begin
            mat_A    <= '0;
            mat_B    <= '0;
            sign     <= op_sign;
            load_idx <= '0;
          end
        end
        LOAD_A, LOAD_B: begin
          if (abort) begin
            mat_A    <= '0;
            mat_B    <= '0;
            load_idx <= '0;
          end else if (xfer) begin
            // Increment wraps 15->0 exactly at the A->B hand-over and at the end of B.
            load_idx <= load_idx + IDX_ONE;
            for (int i = 0; i < N_ENTRIES; i++) begin
              if (load_idx == i[IDX_W-1:0]) begin
                if (state_q == LOAD_A) mat_A[(N_ENTRIES-1-i)*ENTRY_W +: ENTRY_W] <= entry_in;
                else                   mat_B[(N_ENTRIES-1-i)*ENTRY_W +: ENTRY_W] <= entry_in;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mat_operand_loader.sv
// Directed bench for mat_operand_loader: expected operand buses are queued when a load is
// driven and popped when add_en fires.
module tb_mat_operand_loader;

  logic        clk;
  logic        rst;
  logic        start_load;
  logic        op_sign;
  logic        abort;
  logic [3:0]  entry_in;
  logic        entry_valid;
  logic        entry_ready;
  logic [63:0] mat_A;
  logic [63:0] mat_B;
  logic        sign;
  logic        add_en;
  logic        add_finish;
  logic        load_sel;
  logic [3:0]  load_idx;
  logic        busy;
  logic        done;
  logic [2:0]  state_dbg;

  mat_operand_loader dut (
    .clk         (clk),
    .rst         (rst),
    .start_load  (start_load),
    .op_sign     (op_sign),
    .abort       (abort),
    .entry_in    (entry_in),
    .entry_valid (entry_valid),
    .entry_ready (entry_ready),
    .mat_A       (mat_A),
    .mat_B       (mat_B),
    .sign        (sign),
    .add_en      (add_en),
    .add_finish  (add_finish),
    .load_sel    (load_sel),
    .load_idx    (load_idx),
    .busy        (busy),
    .done        (done),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_pass   = 0;
  int n_checks = 0;
  int en_cnt   = 0;
  int exp_en   = 0;

  logic [63:0] exp_q[$];
  logic        exp_sign_q[$];

  always @(posedge clk) if (add_en === 1'b1) en_cnt++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Drives one complete load; returns at the negedge of the FIRE cycle.
  task automatic run_load(input logic s, input logic [63:0] a, input logic [63:0] b,
                          input bit gaps, input bit chaos);
    logic [63:0] ea, eb;
    logic        es;
    exp_q.push_back(a);
    exp_q.push_back(b);
    exp_sign_q.push_back(s);
    start_load = 1'b1;
    op_sign    = s;
    @(negedge clk);
    start_load = 1'b0;
    op_sign    = ~s;
    check("start_busy", busy, 1);
    check("start_mat_A_clear", mat_A, 0);
    check("start_mat_B_clear", mat_B, 0);
    check("start_sign", sign, s);
    check("start_idx", load_idx, 0);
    for (int i = 0; i < 32; i++) begin
      if (gaps) begin
        int ng;
        ng = $urandom_range(1, 2);
        for (int g = 0; g < ng; g++) begin
          entry_valid = 1'b0;
          entry_in    = 4'($urandom_range(0, 15));
          if (chaos) begin
            start_load = 1'($urandom_range(0, 1));
            add_finish = 1'($urandom_range(0, 1));
          end
          @(negedge clk);
          start_load = 1'b0;
          add_finish = 1'b0;
        end
      end
      check("gap_idx_hold", load_idx, i % 16);
      check("load_sel", load_sel, (i >= 16) ? 1 : 0);
      check("entry_ready", entry_ready, 1);
      entry_valid = 1'b1;
      entry_in    = (i < 16) ? a[63-4*i -: 4] : b[63-4*(i-16) -: 4];
      @(negedge clk);
    end
    entry_valid = 1'b0;
    exp_en++;
    check("add_en_after_32nd", add_en, 1);
    check("fire_busy", busy, 1);
    if (exp_q.size() >= 2 && exp_sign_q.size() >= 1) begin
      ea = exp_q.pop_front();
      eb = exp_q.pop_front();
      es = exp_sign_q.pop_front();
      check("sb_mat_A", mat_A, ea);
      check("sb_mat_B", mat_B, eb);
      check("sb_sign", sign, es);
    end
  endtask

  // From the FIRE negedge: one WAIT cycle, then add_finish, then DONE.
  task automatic finish_load(input logic s, input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    check("wait_add_en_low", add_en, 0);
    check("wait_busy", busy, 1);
    check("wait_sign", sign, s);
    check("add_en_pulses", en_cnt, exp_en);
    add_finish = 1'b1;
    @(negedge clk);
    add_finish = 1'b0;
    check("done_after_finish", done, 1);
    check("done_busy_low", busy, 0);
    check("done_mat_A", mat_A, a);
    check("done_mat_B", mat_B, b);
    check("done_sign", sign, s);
  endtask

  initial begin
    logic [63:0] a, b;
    rst         = 1'b1;
    start_load  = 1'b0;
    op_sign     = 1'b0;
    abort       = 1'b0;
    entry_in    = 4'h0;
    entry_valid = 1'b0;
    add_finish  = 1'b0;

    // 1: reset then idle
    repeat (2) @(negedge clk);
    check("rst_mat_A", mat_A, 0);
    check("rst_mat_B", mat_B, 0);
    check("rst_sign", sign, 0);
    check("rst_idx", load_idx, 0);
    check("rst_state", state_dbg, 0);
    rst = 1'b0;
    entry_valid = 1'b1;
    repeat (5) @(negedge clk);
    entry_valid = 1'b0;
    check("idle_ready", entry_ready, 0);
    check("idle_busy", busy, 0);
    check("idle_idx", load_idx, 0);
    check("idle_no_add_en", en_cnt, 0);

    // 2: full add load, valid held
    a = 64'h123456789ABCDEF0;
    b = 64'h2222222222222222;
    run_load(1'b0, a, b, 1'b0, 1'b0);
    finish_load(1'b0, a, b);

    // 3: gaps with start_load / add_finish noise during the load
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    run_load(1'b1, a, b, 1'b1, 1'b1);
    finish_load(1'b1, a, b);

    // 5: subtract, then reload from DONE with add
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    run_load(1'b1, a, b, 1'b0, 1'b0);
    finish_load(1'b1, a, b);
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    run_load(1'b0, a, b, 1'b0, 1'b0);
    finish_load(1'b0, a, b);

    // 6a: add_finish already high in FIRE takes effect only from WAIT
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    run_load(1'b1, a, b, 1'b0, 1'b0);
    add_finish = 1'b1;
    @(negedge clk);
    check("early_finish_not_done", done, 0);
    check("early_finish_busy", busy, 1);
    @(negedge clk);
    add_finish = 1'b0;
    check("early_finish_done", done, 1);
    check("early_pulses", en_cnt, exp_en);

    // 6b: abort/start_load ignored in FIRE/WAIT, then async reset mid-WAIT
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    run_load(1'b0, a, b, 1'b0, 1'b0);
    abort      = 1'b1;
    start_load = 1'b1;
    op_sign    = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("prot_busy", busy, 1);
      check("prot_done", done, 0);
      check("prot_mat_A", mat_A, a);
      check("prot_mat_B", mat_B, b);
      check("prot_sign", sign, 0);
    end
    abort      = 1'b0;
    start_load = 1'b0;
    op_sign    = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_rst_mat_A", mat_A, 0);
    check("async_rst_mat_B", mat_B, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_done", done, 0);
    check("async_rst_state", state_dbg, 0);
    #1 rst = 1'b0;
    @(negedge clk);

    // 4: abort at B idx 7 with a same-cycle valid entry
    start_load = 1'b1;
    @(negedge clk);
    start_load = 1'b0;
    for (int i = 0; i < 23; i++) begin
      entry_valid = 1'b1;
      entry_in    = 4'($urandom_range(1, 15));
      @(negedge clk);
    end
    check("pre_abort_sel", load_sel, 1);
    check("pre_abort_idx", load_idx, 7);
    entry_in = 4'hF;
    abort    = 1'b1;
    @(negedge clk);
    abort       = 1'b0;
    entry_valid = 1'b0;
    check("abort_state", state_dbg, 0);
    check("abort_busy", busy, 0);
    check("abort_mat_A", mat_A, 0);
    check("abort_mat_B", mat_B, 0);
    check("abort_idx", load_idx, 0);
    check("abort_ready", entry_ready, 0);
    check("abort_pulses", en_cnt, exp_en);
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    run_load(1'b1, a, b, 1'b1, 1'b0);
    finish_load(1'b1, a, b);

    check("sb_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
